move_queue_sequencer: RTL and testbench

Parametrised move queue and execution sequencer between the solving algorithm and `move_to_step`. Accepts packed batches of 4-bit move codes, buffers up to DEPTH moves in a FIFO, and issues them one at a time to the stepper driver under a start/done handshake. Compared with the fixed-size sequencer, it adds:
- multi-batch loading that can overlap execution;
- a programmable settle gap between moves;
- pause;
- sticky overflow reporting.

---
 rtl/move_queue_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_move_queue_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_queue_sequencer.sv
// move_queue_sequencer
// Buffers 4-bit move codes from packed batches in a FIFO and issues them one at a time to the
// stepper driver through a start/done handshake. Loading can overlap execution.
// Ports:
//   clock_25mhz, reset        : clock and synchronous active-high reset
//   batch_in/valid/ready      : packed batch input (slot 0 executes first) and handshake
//   seq_complete              : sticky go request
//   pause                     : holds issue of the next move
//   next_move, move_start     : move code and one-cycle start pulse to the stepper
//   move_done                 : stepper completion
//   num_moves, curr_step      : saturating counts of queued and completed moves
//   busy, seq_done, overflow  : status flags (seq_done and overflow are sticky)
module move_queue_sequencer #(
  parameter int unsigned BATCH_MOVES   = 50,
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 25000
) (
  input  logic                     clock_25mhz,
  input  logic                     reset,
  input  logic [4*BATCH_MOVES-1:0] batch_in,
  input  logic                     batch_valid,
  output logic                     batch_ready,
  input  logic                     seq_complete,
  input  logic                     pause,
  output logic [3:0]               next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic [CNT_W-1:0]         num_moves,
  output logic [CNT_W-1:0]         curr_step,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     overflow
);

  localparam int unsigned BW  = 4 * BATCH_MOVES;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned OW  = PW + 1;
  localparam int unsigned SLW = $clog2(BATCH_MOVES + 1);
  localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic {LIdle, LScan} l_state_e;
  typedef enum logic [2:0] {XIdle, XIssue, XWait, XSettle, XDone} x_state_e;

  l_state_e         l_state_q, l_state_d;
  x_state_e         x_state_q, x_state_d;
  logic [BW-1:0]    shreg_q, shreg_d;
  logic [SLW-1:0]   slot_q, slot_d;
  logic             batch_ready_q, batch_ready_d;
  logic [3:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] num_moves_q, num_moves_d, curr_step_q, curr_step_d;
  logic             go_q, go_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [3:0]       next_move_q, next_move_d;
  logic             move_start_q, move_start_d;
  logic             busy_q, busy_d, seq_done_q, seq_done_d;

  logic [3:0] slot_code;
  logic       slot_valid, accept, push, push_ok, pop, fifo_empty, fifo_full;

  assign slot_code  = shreg_q[3:0];
  assign slot_valid = (slot_code >= 4'd2) && (slot_code <= 4'd13);
  assign accept     = batch_valid && batch_ready_q;
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OW'(DEPTH));

  // Loader
  always_comb begin
    l_state_d = l_state_q;
    shreg_d   = shreg_q;
    slot_d    = slot_q;
    push      = 1'b0;
    unique case (l_state_q)
      LIdle: begin
        if (accept) begin
          shreg_d   = batch_in;
          slot_d    = '0;
          l_state_d = LScan;
        end
      end
      LScan: begin
        if (slot_valid) begin
          push    = 1'b1;
          shreg_d = shreg_q >> 4;
          slot_d  = slot_q + SLW'(1);
          if (slot_q == SLW'(BATCH_MOVES - 1)) l_state_d = LIdle;
        end else begin
          l_state_d = LIdle;
        end
      end
      default: l_state_d = LIdle;
    endcase
    // Ready follows the registered state, so it only returns one cycle after the scan ends.
    batch_ready_d = (l_state_q == LIdle) && !accept;
  end

  // Execute FSM
  always_comb begin
    x_state_d   = x_state_q;
    settle_d    = settle_q;
    curr_step_d = curr_step_q;
    next_move_d = next_move_q;
    pop         = 1'b0;
    unique case (x_state_q)
      XIdle: begin
        if (go_q && !fifo_empty && !pause) begin
          x_state_d   = XIssue;
          next_move_d = mem_q[rd_ptr_q];
          pop         = 1'b1;
        end else if (go_q && fifo_empty && (l_state_q == LIdle)) begin
          x_state_d = XDone;
        end
      end
      XIssue: x_state_d = XWait;
      XWait: begin
        if (move_done) begin
          if (curr_step_q != {CNT_W{1'b1}}) curr_step_d = curr_step_q + CNT_W'(1);
          settle_d  = SW'(SETTLE_CYCLES);
          x_state_d = XSettle;
        end
      end
      XSettle: begin
        if (settle_q == '0) begin
          if (!pause) x_state_d = XIdle;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      XDone:   x_state_d = XDone;
      default: x_state_d = XIdle;
    endcase
    move_start_d = (x_state_d == XIssue);
    busy_d       = (x_state_d != XIdle) && (x_state_d != XDone);
    seq_done_d   = (x_state_d == XDone);
    go_d         = go_q | seq_complete;
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot a full push needs.
  always_comb begin
    push_ok     = push && (!fifo_full || pop);
    overflow_d  = overflow_q | (push && !push_ok);
    wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d       = occ_q;
    if (push_ok && !pop) occ_d = occ_q + OW'(1);
    if (!push_ok && pop) occ_d = occ_q - OW'(1);
    num_moves_d = num_moves_q;
    if (push_ok && (num_moves_q != {CNT_W{1'b1}})) num_moves_d = num_moves_q + CNT_W'(1);
  end

  always_ff @(posedge clock_25mhz) begin
    if (push_ok) mem_q[wr_ptr_q] <= slot_code;
  end

  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      l_state_q     <= LIdle;
      x_state_q     <= XIdle;
      shreg_q       <= '0;
      slot_q        <= '0;
      batch_ready_q <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      overflow_q    <= 1'b0;
      num_moves_q   <= '0;
      curr_step_q   <= '0;
      go_q          <= 1'b0;
      settle_q      <= '0;
      next_move_q   <= '0;
      move_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      l_state_q     <= l_state_d;
      x_state_q     <= x_state_d;
      shreg_q       <= shreg_d;
      slot_q        <= slot_d;
      batch_ready_q <= batch_ready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      overflow_q    <= overflow_d;
      num_moves_q   <= num_moves_d;
      curr_step_q   <= curr_step_d;
      go_q          <= go_d;
      settle_q      <= settle_d;
      next_move_q   <= next_move_d;
      move_start_q  <= move_start_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
    end
  end

  assign batch_ready = batch_ready_q;
  assign next_move   = next_move_q;
  assign move_start  = move_start_q;
  assign num_moves   = num_moves_q;
  assign curr_step   = curr_step_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_move_queue_sequencer.sv
// Directed bench for move_queue_sequencer with a small FIFO and short settle gap.
module tb_move_queue_sequencer;

  localparam int unsigned BM       = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = 8;
  localparam int unsigned SETTLE   = 4;
  localparam int          STEP_LAT = 10;
  // start -> done sampled (STEP_LAT+1) -> settle+idle+issue (SETTLE+2)
  localparam int          GAP      = STEP_LAT + 1 + SETTLE + 2;

  logic          clock_25mhz = 1'b0;
  logic          reset = 1'b1;
  logic [4*BM-1:0] batch_in = '0;
  logic          batch_valid = 1'b0;
  logic          batch_ready;
  logic          seq_complete = 1'b0;
  logic          pause = 1'b0;
  logic [3:0]    next_move;
  logic          move_start;
  logic          move_done = 1'b0;
  logic [CW-1:0] num_moves, curr_step;
  logic          busy, seq_done, overflow;

  move_queue_sequencer #(
    .BATCH_MOVES(BM), .DEPTH(DEPTH), .CNT_W(CW), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock_25mhz (clock_25mhz),
    .reset       (reset),
    .batch_in    (batch_in),
    .batch_valid (batch_valid),
    .batch_ready (batch_ready),
    .seq_complete(seq_complete),
    .pause       (pause),
    .next_move   (next_move),
    .move_start  (move_start),
    .move_done   (move_done),
    .num_moves   (num_moves),
    .curr_step   (curr_step),
    .busy        (busy),
    .seq_done    (seq_done),
    .overflow    (overflow)
  );

  always #20 clock_25mhz = ~clock_25mhz;

  int cyc = 0;
  always @(posedge clock_25mhz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int start_cyc[$];
  int start_code[$];

  // Start monitor
  initial forever begin
    @(negedge clock_25mhz);
    if (move_start) begin
      start_cyc.push_back(cyc);
      start_code.push_back(int'(next_move));
    end
  end

  // Stepper model: done pulse STEP_LAT cycles after the start cycle
  initial forever begin
    @(negedge clock_25mhz);
    if (move_start) begin
      repeat (STEP_LAT) @(negedge clock_25mhz);
      move_done = 1'b1;
      @(negedge clock_25mhz);
      move_done = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_at(input int i);
    return (i < start_code.size()) ? start_code[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock_25mhz);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    batch_valid  = 1'b0;
    seq_complete = 1'b0;
    pause        = 1'b0;
    step(2);
    reset = 1'b0;
    start_cyc.delete();
    start_code.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_batch_ready"}, int'(batch_ready), 1);
    check_eq({tag, "_move_start"}, int'(move_start), 0);
    check_eq({tag, "_next_move"}, int'(next_move), 0);
    check_eq({tag, "_num_moves"}, int'(num_moves), 0);
    check_eq({tag, "_curr_step"}, int'(curr_step), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_seq_done"}, int'(seq_done), 0);
    check_eq({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Offers a batch and returns how many cycles batch_ready stayed low.
  task automatic send_batch(input logic [4*BM-1:0] b, output int low);
    batch_in    = b;
    batch_valid = 1'b1;
    step(1);
    batch_valid = 1'b0;
    low = 0;
    while (!batch_ready && low < 100) begin
      low++;
      step(1);
    end
  endtask

  task automatic pulse_go();
    seq_complete = 1'b1;
    step(1);
    seq_complete = 1'b0;
  endtask

  task automatic wait_seq_done(input string tag, input int limit, output int seen);
    int n = 0;
    while (!seq_done && n < limit) begin
      step(1);
      n++;
    end
    seen = cyc;
    if (!seq_done) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_starts(input string tag, input int cnt, input int limit);
    int n = 0;
    while (start_cyc.size() < cnt && n < limit) begin
      step(1);
      n++;
    end
    if (start_cyc.size() < cnt) check_eq({tag, "_timeout"}, start_cyc.size(), cnt);
  endtask

  initial begin
    int low;
    int seen;
    int k;
    int t1_codes[3] = '{2, 4, 3};
    int t3_codes[4] = '{2, 3, 4, 5};
    int t4_codes[5] = '{2, 4, 6, 8, 12};

    // Test 1: R,U,Ri then go
    do_reset();
    check_reset_vals("rst");
    send_batch(32'h0000_0342, low);
    check_eq("t1_ready_low", low, 5);
    pulse_go();
    wait_seq_done("t1_done", 300, seen);
    step(1);
    check_eq("t1_starts", start_cyc.size(), 3);
    for (int i = 0; i < 3; i++) check_eq($sformatf("t1_code%0d", i), code_at(i), t1_codes[i]);
    for (int i = 1; i < 3; i++)
      check_eq($sformatf("t1_gap%0d", i), cyc_at(i) - cyc_at(i - 1), GAP);
    check_eq("t1_curr_step", int'(curr_step), 3);
    check_eq("t1_num_moves", int'(num_moves), 3);
    check_eq("t1_seq_done", int'(seq_done), 1);
    check_eq("t1_busy", int'(busy), 0);
    check_eq("t1_overflow", int'(overflow), 0);

    // Test 2: empty batch
    do_reset();
    send_batch('0, low);
    check_eq("t2_ready_low", low, 2);
    pulse_go();
    wait_seq_done("t2_done", 50, seen);
    check_eq("t2_starts", start_cyc.size(), 0);
    check_eq("t2_num_moves", int'(num_moves), 0);
    check_eq("t2_seq_done", int'(seq_done), 1);

    // Test 3: six moves into a four-entry FIFO with go low
    do_reset();
    send_batch(32'h0076_5432, low);
    check_eq("t3_ready_low", low, 8);
    step(5);
    check_eq("t3_num_moves", int'(num_moves), 4);
    check_eq("t3_overflow", int'(overflow), 1);
    check_eq("t3_busy_nogo", int'(busy), 0);
    check_eq("t3_starts_nogo", start_cyc.size(), 0);
    pulse_go();
    wait_seq_done("t3_done", 500, seen);
    check_eq("t3_starts", start_cyc.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t3_code%0d", i), code_at(i), t3_codes[i]);
    check_eq("t3_curr_step", int'(curr_step), 4);
    check_eq("t3_overflow_sticky", int'(overflow), 1);

    // Test 4: second batch while the first executes
    do_reset();
    send_batch(32'h0000_0042, low);
    pulse_go();
    wait_starts("t4_first", 1, 50);
    send_batch(32'h0000_0C86, low);
    check_eq("t4_ready_low_b", low, 5);
    wait_seq_done("t4_done", 500, seen);
    check_eq("t4_starts_at_done", start_cyc.size(), 5);
    check_eq("t4_step_at_done", int'(curr_step), 5);
    check_eq("t4_done_cycle", seen - cyc_at(4), GAP);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t4_code%0d", i), code_at(i), t4_codes[i]);
    check_eq("t4_num_moves", int'(num_moves), 5);
    check_eq("t4_overflow", int'(overflow), 0);

    // Test 5: pause during the in-flight move
    do_reset();
    send_batch(32'h0000_0042, low);
    pulse_go();
    wait_starts("t5_first", 1, 50);
    step(3);
    pause = 1'b1;
    step(100);
    check_eq("t5_starts_paused", start_cyc.size(), 1);
    check_eq("t5_step_paused", int'(curr_step), 1);
    check_eq("t5_busy_paused", int'(busy), 1);
    k = cyc;
    pause = 1'b0;
    wait_starts("t5_second", 2, 50);
    check_eq("t5_release_lat", cyc_at(1) - k, 2);
    check_eq("t5_code1", code_at(1), 4);
    wait_seq_done("t5_done", 100, seen);
    check_eq("t5_curr_step", int'(curr_step), 2);

    // Test 6: reset while waiting on the stepper
    do_reset();
    send_batch(32'h0000_0042, low);
    pulse_go();
    wait_starts("t6_first", 1, 50);
    step(3);
    reset = 1'b1;
    step(1);
    check_reset_vals("t6_rst");
    reset = 1'b0;
    step(20);
    check_eq("t6_curr_step", int'(curr_step), 0);
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_seq_done", int'(seq_done), 0);
    check_eq("t6_starts", start_cyc.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
